// File: rtl/aes_sbox_masked_pkg.sv
// ---------------------------------------------------------------------------
// aes_sbox_masked_pkg
// Shared types, constants and GF(2^2) helper functions for the masked AES
// S-box datapath.
//   GF(2^2) elements use normal basis [Omega^2, Omega]:
//     bit[1] = Omega^2 coefficient, bit[0] = Omega coefficient.
//   GF(2^4) nibbles are {hi[3:2], lo[1:0]} over GF(2^2), normal basis [W^4, W].
// No ports (package).
// ---------------------------------------------------------------------------
package aes_sbox_masked_pkg;

  localparam logic [3:0] GF4_ONE  = 4'hF;
  localparam logic [3:0] GF4_ZERO = 4'h0;
  localparam int         SHARES   = 2;

  typedef logic [1:0] gf2_t;      // GF(2^2) element
  typedef logic [2:0] gf2_fac_t;  // factor expansion {x1^x0, x1, x0}
  typedef logic [3:0] nibble_t;   // GF(2^4) element

  // Factor expansion of a GF(2^2) element. The expansion is linear, so the
  // expansion of a sum is the XOR of the expansions; the multiplier relies on
  // this to share factors between its three GF(2^2) products.
  function automatic gf2_fac_t f_expand(input gf2_t x);
    return {x[1] ^ x[0], x[1], x[0]};
  endfunction

  // GF(2^2) product from pre-expanded factors: the middle term is shared by
  // both output bits.
  function automatic gf2_t mul_sf(input gf2_fac_t fx, input gf2_fac_t fy);
    logic e;
    e = fx[2] & fy[2];
    return {(fx[1] & fy[1]) ^ e, (fx[0] & fy[0]) ^ e};
  endfunction

  // Multiply by the GF(2^4) extension constant N.
  function automatic gf2_t scl_n(input gf2_t t);
    return {t[0], t[1] ^ t[0]};
  endfunction

endpackage

// File: rtl/gf_muls_4_masked.sv
// ---------------------------------------------------------------------------
// gf_muls_4_masked
// Combinational GF(2^4) multiplier built from three shared-factor GF(2^2)
// multipliers:
//   ph = xh*yh, pl = xl*yl, p = N*((xh^xl)*(yh^yl)), z = {ph^p, pl^p}.
// Ports:
//   i_x  in  4  multiplicand (one share)
//   i_y  in  4  multiplier   (one share)
//   o_z  out 4  product
// ---------------------------------------------------------------------------
module gf_muls_4_masked
  import aes_sbox_masked_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic [3:0] o_z
);

  gf2_fac_t w_fxh, w_fxl, w_fyh, w_fyl;
  gf2_t     w_ph, w_pl, w_pm, w_p;

  assign w_fxh = f_expand(i_x[3:2]);
  assign w_fxl = f_expand(i_x[1:0]);
  assign w_fyh = f_expand(i_y[3:2]);
  assign w_fyl = f_expand(i_y[1:0]);

  // Factors of the summed halves are derived from the half factors rather
  // than re-expanded from xh^xl.
  assign w_ph = mul_sf(w_fxh, w_fyh);
  assign w_pl = mul_sf(w_fxl, w_fyl);
  assign w_pm = mul_sf(w_fxh ^ w_fxl, w_fyh ^ w_fyl);
  assign w_p  = scl_n(w_pm);

  assign o_z = {w_ph ^ w_p, w_pl ^ w_p};

endmodule

// File: rtl/gf_muls_4_masked_dom.sv
// ---------------------------------------------------------------------------
// gf_muls_4_masked_dom
// Two-stage, 2-share domain-oriented masked GF(2^4) multiplier.
//   Stage 1 registers the four share products; the two cross-domain terms are
//   refreshed with rnd before registering, so compression in stage 2 never
//   sees an unrefreshed cross-domain product.
//   Stage 2 compresses into the output shares.
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  operand shares + rnd valid
//   in_ready   out  1  block accepts this cycle
//   a_sh0/1    in   4  operand A shares (A = a_sh0 ^ a_sh1)
//   b_sh0/1    in   4  operand B shares
//   rnd        in   4  fresh mask, consumed once per accepted transfer
//   out_valid  out  1  product shares valid
//   out_ready  in   1  consumer accepts this cycle
//   q_sh0/1    out  4  product shares (q_sh0 ^ q_sh1 = A*B)
// Parameter:
//   CLEAR_ON_IDLE  1: data registers loading a bubble are zeroed; 0: hold.
// ---------------------------------------------------------------------------
module gf_muls_4_masked_dom
  import aes_sbox_masked_pkg::*;
#(
  parameter bit CLEAR_ON_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a_sh0,
  input  logic [3:0] a_sh1,
  input  logic [3:0] b_sh0,
  input  logic [3:0] b_sh1,
  input  logic [3:0] rnd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] q_sh0,
  output logic [3:0] q_sh1
);

  // Combinational share products
  nibble_t w_p00, w_p11, w_p01, w_p10;

  gf_muls_4_masked u_mul_p00 (.i_x(a_sh0), .i_y(b_sh0), .o_z(w_p00));
  gf_muls_4_masked u_mul_p11 (.i_x(a_sh1), .i_y(b_sh1), .o_z(w_p11));
  gf_muls_4_masked u_mul_p01 (.i_x(a_sh0), .i_y(b_sh1), .o_z(w_p01));
  gf_muls_4_masked u_mul_p10 (.i_x(a_sh1), .i_y(b_sh0), .o_z(w_p10));

  // Pipeline state
  logic    r_v1, r_v2;
  nibble_t r_p00, r_p11, r_c01, r_c10;
  nibble_t r_q0, r_q1;

  // Flow control: a stage loads when it is empty or the stage after it loads.
  // in_ready depends only on register state and out_ready, never on in_valid.
  logic w_s2_load, w_s1_load, w_accept;

  assign w_s2_load = !r_v2 || out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign w_accept  = in_valid && w_s1_load;

  // Stage 1: share products, cross-domain terms refreshed with rnd.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well as valids so no stale share
      // material survives a reset into the next transfer.
      r_v1  <= 1'b0;
      r_p00 <= GF4_ZERO;
      r_p11 <= GF4_ZERO;
      r_c01 <= GF4_ZERO;
      r_c10 <= GF4_ZERO;
    end else if (w_s1_load) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_p00 <= w_p00;
        r_p11 <= w_p11;
        r_c01 <= w_p01 ^ rnd;
        r_c10 <= w_p10 ^ rnd;
      end else if (CLEAR_ON_IDLE) begin
        r_p00 <= GF4_ZERO;
        r_p11 <= GF4_ZERO;
        r_c01 <= GF4_ZERO;
        r_c10 <= GF4_ZERO;
      end
    end
  end

  // Stage 2: per-domain compression into the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_q0 <= GF4_ZERO;
      r_q1 <= GF4_ZERO;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q0 <= r_p00 ^ r_c01;
        r_q1 <= r_p11 ^ r_c10;
      end else if (CLEAR_ON_IDLE) begin
        r_q0 <= GF4_ZERO;
        r_q1 <= GF4_ZERO;
      end
    end
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_v2;
  assign q_sh0     = r_q0;
  assign q_sh1     = r_q1;

endmodule

// File: tb/tb_gf_muls_4_masked_dom.sv
// ---------------------------------------------------------------------------
// tb_gf_muls_4_masked_dom
// Self-checking bench for gf_muls_4_masked_dom. The reference multiplier
// works in GF(2^2) through discrete logs of Omega and multiplies by
// N = Omega^2, then assembles GF(2^4) products from the half products.
// ---------------------------------------------------------------------------
module tb_gf_muls_4_masked_dom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_sh0, a_sh1, b_sh0, b_sh1, rnd;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q_sh0, q_sh1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int out_n    = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q0[$];
  logic [3:0] obs_q1[$];

  gf_muls_4_masked_dom dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_sh0    (a_sh0),
    .a_sh1    (a_sh1),
    .b_sh0    (b_sh0),
    .b_sh1    (b_sh1),
    .rnd      (rnd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q_sh0    (q_sh0),
    .q_sh1    (q_sh1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cyc=%0d required end", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // GF(2^2) in [Omega^2, Omega]: 2'b11 = 1, 2'b01 = Omega, 2'b10 = Omega^2.
  function automatic int gf4_log(input logic [1:0] x);
    case (x)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] gf4_exp(input int e);
    case (e % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    return gf4_exp(gf4_log(x) + gf4_log(y));
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] ph, pl, p;
    ph = gf4_mul(x[3:2], y[3:2]);
    pl = gf4_mul(x[1:0], y[1:0]);
    p  = gf4_mul(gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]), 2'b10);
    return {ph ^ p, pl ^ p};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  // Output monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("out_has_pending_expect", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("q_xor", q_sh0 ^ q_sh1, exp_q.pop_front());
      obs_q0.push_back(q_sh0);
      obs_q1.push_back(q_sh1);
      out_n++;
    end
  end

  // Present one transfer and hold it until accepted; returns 1 time unit after
  // the accepting edge with in_valid dropped.
  task automatic send(input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic [3:0] r);
    int guard;
    guard    = 0;
    a_sh0    = a0;
    a_sh1    = a1;
    b_sh0    = b0;
    b_sh1    = b1;
    rnd      = r;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      guard++;
      if (guard > 50) begin
        check("send_timeout_in_ready", {31'd0, in_ready}, 1);
        break;
      end
    end
    exp_q.push_back(gf16_mul(a0 ^ a1, b0 ^ b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a, b, s0, s1, h0, h1;
    int start, base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_sh0 = 4'h0; a_sh1 = 4'h0; b_sh0 = 4'h0; b_sh1 = 4'h0; rnd = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_q_sh0", q_sh0, 0);
    check("rst_q_sh1", q_sh1, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    // 1. A=9, B=one, latency of two cycles
    obs_q0.delete(); obs_q1.delete();
    send(4'h5, 4'hC, 4'h3, 4'hC, 4'hA);
    @(negedge clk);
    check("t1_valid_after_1", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("t1_valid_after_2", {31'd0, out_valid}, 1);
    check("t1_xor_9", q_sh0 ^ q_sh1, 4'h9);
    drain("t1_drain");
    check("t1_idle_clear_q0", q_sh0, 0);
    check("t1_idle_clear_q1", q_sh1, 0);

    // 2. A=7, B=0 with equal B shares: both output shares equal rnd
    obs_q0.delete(); obs_q1.delete();
    send(4'h2, 4'h5, 4'h6, 4'h6, 4'h5);
    drain("t2_drain");
    check("t2_count", obs_q0.size(), 1);
    if (obs_q0.size() > 0) begin
      check("t2_q_sh0", obs_q0[0], 4'h5);
      check("t2_q_sh1", obs_q1[0], 4'h5);
    end

    // 3. All 256 pairs back to back, random sharings and masks
    base  = out_n;
    start = cyc;
    for (int k = 0; k < 256; k++) begin
      a  = 4'(k >> 4);
      b  = 4'(k);
      s0 = 4'($urandom);
      s1 = 4'($urandom);
      send(s0, s0 ^ a, s1, s1 ^ b, 4'($urandom));
    end
    check("t3_accept_cycles", cyc - start, 256);
    drain("t3_drain");
    check("t3_out_count", out_n - base, 256);

    // 4. Same shares, rnd=0 then rnd=F: q_sh0 differs by exactly F
    obs_q0.delete(); obs_q1.delete();
    send(4'h3, 4'h5, 4'h3, 4'h5, 4'h0);
    send(4'h3, 4'h5, 4'h3, 4'h5, 4'hF);
    drain("t4_drain");
    check("t4_count", obs_q0.size(), 2);
    if (obs_q0.size() > 1) check("t4_q_sh0_delta", obs_q0[0] ^ obs_q0[1], 4'hF);

    // 5. Backpressure: 4 transfers, consumer stalled for 3 edges
    base = out_n;
    out_ready = 1'b0;
    send(4'h1, 4'h7, 4'hE, 4'h2, 4'($urandom));
    send(4'hB, 4'h4, 4'h9, 4'h0, 4'($urandom));
    @(negedge clk);
    check("t5_in_ready_full", {31'd0, in_ready}, 0);
    check("t5_out_valid_held", {31'd0, out_valid}, 1);
    h0 = q_sh0;
    h1 = q_sh1;
    @(posedge clk);
    #1;
    check("t5_q_sh0_stable", q_sh0, h0);
    check("t5_q_sh1_stable", q_sh1, h1);
    check("t5_in_ready_still_0", {31'd0, in_ready}, 0);
    out_ready = 1'b1;
    send(4'h6, 4'hD, 4'h8, 4'h3, 4'($urandom));
    send(4'hF, 4'hF, 4'h5, 4'hA, 4'($urandom));
    drain("t5_drain");
    check("t5_out_count", out_n - base, 4);

    // 6. Reset with both stages full discards in-flight products
    out_ready = 1'b0;
    send(4'h9, 4'h2, 4'h4, 4'h7, 4'($urandom));
    send(4'hC, 4'h1, 4'hD, 4'h6, 4'($urandom));
    @(negedge clk);
    check("t6_full_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    base = out_n;
    @(posedge clk);
    #1;
    check("t6_rst_out_valid", {31'd0, out_valid}, 0);
    check("t6_rst_q_sh0", q_sh0, 0);
    check("t6_rst_q_sh1", q_sh1, 0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_ghost_outputs", out_n - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
